// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
//
// Owns the PC, issues word fetches to instruction memory, records the address
// of every accepted fetch in a 2-deep in-flight queue, and buffers returned
// instructions (tagged with their PC) in a 2-entry FIFO whose head is
// presented to decode.  A redirect from execute reloads the PC, empties the
// FIFO and discards every response still in flight.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   imem_req_*        fetch request channel (valid/ready, word address)
//   imem_resp_*       in-order fetch responses, at least 1 cycle after accept
//   redirect_*        taken branch / jump target from execute
//   instr_valid/ready head of the instruction buffer toward decode
//   instr, instr_pc   head instruction and its PC
//   instr_pc_plus4    instr_pc + 4 (wraps)
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic [DATA_WIDTH-1:0] instr_pc_plus4
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
    } entry_t;

    state_t                         state;
    logic [DATA_WIDTH-1:0]          pc;
    logic [1:0]                     outstanding;
    logic [1:0]                     drop;
    logic [1:0]                     fifo_count;
    entry_t [1:0]                   fifo;
    logic                           fifo_rd;
    logic                           fifo_wr;
    logic [1:0][DATA_WIDTH-1:0]     inflight;
    logic                           q_rd;
    logic                           q_wr;

    logic                           req_fire;
    logic                           resp_take;
    logic                           push;
    logic                           pop;
    logic [1:0]                     drop_next;
    logic [2:0]                     credits_used;

    // Every request reserves a FIFO slot up front: in-flight plus buffered
    // never exceeds the FIFO depth, so a response always has room.
    assign credits_used   = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = (state == RUN) && !redirect_valid && (credits_used < 3'd2);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Guard against a response with nothing outstanding (memory misbehaving)
    // so the counters can never wrap.
    assign resp_take = imem_resp_valid && (outstanding != 2'd0);
    assign drop_next = outstanding - {1'b0, resp_take};

    // During a redirect the FIFO is cleared, so neither a push of the
    // arriving response nor a decode pop has any effect.
    assign push = resp_take && (state == RUN) && !redirect_valid;
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid    = (fifo_count != 2'd0);
    assign instr          = fifo[fifo_rd].instr;
    assign instr_pc       = fifo[fifo_rd].pc;
    assign instr_pc_plus4 = instr_pc + DATA_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fifo_count  <= '0;
            fifo        <= '0;
            fifo_rd     <= 1'b0;
            fifo_wr     <= 1'b0;
            inflight    <= '0;
            q_rd        <= 1'b0;
            q_wr        <= 1'b0;
        end else begin
            // In-flight PC queue tracks every accepted request and every
            // response, dropped or not, so its head stays aligned with the
            // next response across redirects.
            if (req_fire) begin
                inflight[q_wr] <= pc;
                q_wr           <= ~q_wr;
            end
            if (resp_take) q_rd <= ~q_rd;

            if (redirect_valid) begin
                pc          <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
                outstanding <= drop_next;
                drop        <= drop_next;
                fifo_count  <= '0;
                fifo_rd     <= 1'b0;
                fifo_wr     <= 1'b0;
                state       <= (drop_next != 2'd0) ? FLUSH : RUN;
            end else begin
                if (req_fire) pc <= pc + DATA_WIDTH'(4);

                if (push) begin
                    fifo[fifo_wr] <= '{instr: imem_resp_data, pc: inflight[q_rd]};
                    fifo_wr       <= ~fifo_wr;
                end
                if (pop) fifo_rd <= ~fifo_rd;
                fifo_count  <= fifo_count + 2'(push) - 2'(pop);
                outstanding <= outstanding + 2'(req_fire) - 2'(resp_take);

                case (state)
                    BOOT: state <= RUN;
                    RUN:  state <= RUN;
                    FLUSH: begin
                        if (resp_take) begin
                            drop <= drop - 2'd1;
                            if (drop == 2'd1) state <= RUN;
                        end
                    end
                    default: state <= BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle vectors covering the
// startup stream and a decode stall, plus hand-written redirect, alignment,
// wrap and mid-stream reset sequences.  The memory model answers in order
// after a programmable latency with data = ~address.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    int n_pass  = 0;
    int n_total = 0;
    int lat     = 1;
    int cyc     = 0;

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    always #5 clk = ~clk;

    // In-order memory: request accepted in cycle c answers in cycle c+lat.
    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } mreq_t;
    mreq_t mq[$];

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            if (imem_resp_valid && mq.size() != 0) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (mq.size() != 0 && mq[0].rdy <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~mq[0].addr;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Full output check for one cycle; instruction fields only when valid.
    task automatic chk_out(input string tag, input logic rv, input logic [31:0] addr,
                           input logic iv, input logic [31:0] ipc);
        chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(rv));
        chk({tag, " req_addr"}, imem_req_addr, addr);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(iv));
        if (iv) begin
            chk({tag, " instr_pc"}, instr_pc, ipc);
            chk({tag, " instr"}, instr, ~ipc);
            chk({tag, " pc_plus4"}, instr_pc_plus4, ipc + 32'd4);
        end
    endtask

    // Hold reset across one edge, release it; leaves the bench in cycle 0
    // (BOOT) with the reset values checked.
    task automatic do_reset(input int l);
        @(negedge clk);
        rst = 1'b1; lat = l; instr_ready = 1'b1; redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst req_addr", imem_req_addr, 32'h0);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rst instr", instr, 32'h0);
        chk("rst instr_pc", instr_pc, 32'h0);
        chk("rst pc_plus4", instr_pc_plus4, 32'h4);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        ir;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;
    vec_t tbl[17];

    initial begin
        // Cycles 1..17 after reset, 1-cycle memory; decode stalls cycles 8..12.
        tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        tbl[4]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        tbl[5]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        tbl[6]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        tbl[7]  = '{1'b0, 1'b1, 32'h14, 1'b0, 32'h00};
        tbl[8]  = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[9]  = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[10] = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[11] = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[12] = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[13] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
        tbl[14] = '{1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
        tbl[15] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h18};
        tbl[16] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h1C};

        // Startup stream and stall.
        do_reset(1);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            instr_ready = tbl[i].ir;
            #1;
            chk_out($sformatf("vec c%0d", i + 1), tbl[i].rv, tbl[i].addr, tbl[i].iv, tbl[i].ipc);
        end

        // Redirect with two fetches in flight, 3-cycle memory.
        do_reset(3);
        tick(); tick();                                  // c1, c2: fetch 0x0, 0x4
        @(negedge clk);                                  // c3
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("flush c3 req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk); redirect_valid = 1'b0; #1;       // c4
        chk_out("flush c4", 1'b0, 32'h100, 1'b0, 32'h0);
        tick();                                          // c5
        chk_out("flush c5", 1'b0, 32'h100, 1'b0, 32'h0);
        tick();                                          // c6
        chk_out("flush c6", 1'b1, 32'h100, 1'b0, 32'h0);
        tick();                                          // c7
        chk_out("flush c7", 1'b1, 32'h104, 1'b0, 32'h0);
        tick(); tick(); tick();                          // c10
        chk_out("flush c10", 1'b0, 32'h108, 1'b1, 32'h100);
        tick();                                          // c11
        chk("flush c11 instr_pc", instr_pc, 32'h104);

        // Redirect coinciding with a response and a decode handshake,
        // unaligned target, then a target that wraps.
        do_reset(1);
        tick(); tick();                                  // c1, c2
        @(negedge clk);                                  // c3
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        #1;
        chk("coinc c3 resp_valid", 32'(imem_resp_valid), 32'd1);
        chk("coinc c3 instr_valid", 32'(instr_valid), 32'd1);
        @(negedge clk); redirect_valid = 1'b0; #1;       // c4
        chk_out("coinc c4", 1'b1, 32'h200, 1'b0, 32'h0);
        tick();                                          // c5
        chk_out("coinc c5", 1'b1, 32'h204, 1'b0, 32'h0);
        @(negedge clk);                                  // c6
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap c6 instr_pc", instr_pc, 32'h200);
        @(negedge clk); redirect_valid = 1'b0; #1;       // c7
        chk_out("wrap c7", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick();                                          // c8
        chk_out("wrap c8", 1'b1, 32'h0, 1'b0, 32'h0);
        tick();                                          // c9
        chk_out("wrap c9", instr_valid ? imem_req_valid : 1'b0, imem_req_addr, 1'b1, 32'hFFFF_FFFC);

        // Stall so the FIFO fills, then reset mid-stream.
        @(negedge clk); instr_ready = 1'b0;
        tick(); tick(); tick();
        chk("stall fifo req_valid", 32'(imem_req_valid), 32'd0);
        do_reset(1);
        tick();
        chk_out("restart c1", 1'b1, 32'h0, 1'b0, 32'h0);
        tick();
        chk_out("restart c2", 1'b1, 32'h4, 1'b0, 32'h0);
        tick();
        chk_out("restart c3", 1'b0, 32'h8, 1'b1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
